// File: rtl/max3421e_spi_responder.sv
`default_nettype none
// max3421e_spi_responder: oversampled SPI peripheral emulating the MAX3421E
// command/register protocol with a 32x8 register file, HIRQ status and interrupt.
module max3421e_spi_responder #(
  parameter logic [7:0] REVISION    = 8'h13,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       ss_in,
  input  logic       sclk_in,
  input  logic       mosi_in,
  output logic       miso_out,
  output logic       int_out,
  input  logic [7:0] irq_set_in,
  output logic       wr_valid_out,
  output logic [4:0] wr_addr_out,
  output logic [7:0] wr_data_out
);

  localparam logic [4:0] ADDR_REV  = 5'd18;
  localparam logic [4:0] ADDR_HIRQ = 5'd25;
  localparam logic [4:0] ADDR_HIEN = 5'd26;

  typedef enum logic [1:0] {IDLE, CMD, RDATA, WDATA} state_t;
  state_t state, state_next;

  logic [SYNC_STAGES-1:0] ss_sync, sclk_sync, mosi_sync;
  logic       ss_prev, sclk_prev;
  logic       ss_s, sclk_s, mosi_s;
  logic       ss_fall, ss_rise, sclk_rise, sclk_fall;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [6:0] tx_shift;
  logic [7:0] rx_byte;
  logic       byte_done;
  logic [4:0] addr;
  logic [7:0] regs [32];
  logic [7:0] hirq, hien, hirq_clr, rd_data;

  // Synchronizers reset low so a transfer already under way at reset release
  // never produces an SS falling edge; it is ignored until SS goes high.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ss_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_prev   <= 1'b0;
      sclk_prev <= 1'b0;
    end else begin
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_in};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
      ss_prev   <= ss_s;
      sclk_prev <= sclk_s;
    end
  end

  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign ss_fall   = ss_prev & ~ss_s;
  assign ss_rise   = ~ss_prev & ss_s;
  assign sclk_rise = ~sclk_prev & sclk_s;
  assign sclk_fall = sclk_prev & ~sclk_s;

  assign rx_byte   = {rx_shift, mosi_s};
  assign byte_done = sclk_rise && (bit_cnt == 3'd7);
  assign hirq      = regs[ADDR_HIRQ];
  assign hien      = regs[ADDR_HIEN];
  assign rd_data   = (addr == ADDR_REV) ? REVISION : regs[addr];
  assign hirq_clr  = (wr_valid_out && wr_addr_out == ADDR_HIRQ) ? wr_data_out : 8'h00;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (ss_rise) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (ss_fall) state_next = CMD;
        CMD:     if (byte_done) state_next = rx_byte[1] ? WDATA : RDATA;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bit_cnt      <= 3'd0;
      rx_shift     <= 7'd0;
      tx_shift     <= 7'd0;
      addr         <= 5'd0;
      miso_out     <= 1'b0;
      wr_valid_out <= 1'b0;
      wr_addr_out  <= 5'd0;
      wr_data_out  <= 8'd0;
    end else begin
      wr_valid_out <= 1'b0;
      if (ss_rise) begin
        bit_cnt  <= 3'd0;
        miso_out <= 1'b0;
      end else if (state == IDLE) begin
        if (ss_fall) begin
          bit_cnt  <= 3'd0;
          tx_shift <= hirq[6:0];
          miso_out <= hirq[7];
        end
      end else begin
        if (sclk_rise) begin
          rx_shift <= rx_byte[6:0];
          bit_cnt  <= bit_cnt + 3'd1;
          if (state == CMD && byte_done) addr <= rx_byte[7:3];
          if (state == WDATA && byte_done) begin
            wr_valid_out <= 1'b1;
            wr_addr_out  <= addr;
            wr_data_out  <= rx_byte;
          end
        end
        // The falling edge with bit_cnt back at 0 closes a byte: reload for reads.
        if (sclk_fall) begin
          if (state == RDATA && bit_cnt == 3'd0) begin
            tx_shift <= rd_data[6:0];
            miso_out <= rd_data[7];
          end else begin
            tx_shift <= {tx_shift[5:0], 1'b0};
            miso_out <= tx_shift[6];
          end
        end
      end
    end
  end

  // Commit happens while the strobe is high; set beats clear on HIRQ.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 32; i++) regs[i] <= 8'h00;
      int_out <= 1'b0;
    end else begin
      int_out <= |(hirq & hien);
      if (wr_valid_out && wr_addr_out != ADDR_REV && wr_addr_out != ADDR_HIRQ)
        regs[wr_addr_out] <= wr_data_out;
      regs[ADDR_HIRQ] <= (hirq & ~hirq_clr) | irq_set_in;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_max3421e_spi_responder.sv
`default_nettype none
// tb_max3421e_spi_responder: directed plus randomized SPI transactions checked
// against a register-level reference model of the MAX3421E protocol.
module tb_max3421e_spi_responder;

  localparam logic [7:0] REV = 8'h13;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       ss_in = 1'b1;
  logic       sclk_in = 1'b0;
  logic       mosi_in = 1'b0;
  logic [7:0] irq_set_in = 8'h00;
  logic       miso_out, int_out, wr_valid_out;
  logic [4:0] wr_addr_out;
  logic [7:0] wr_data_out;

  max3421e_spi_responder #(.REVISION(REV), .SYNC_STAGES(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .ss_in(ss_in), .sclk_in(sclk_in),
    .mosi_in(mosi_in), .miso_out(miso_out), .int_out(int_out),
    .irq_set_in(irq_set_in), .wr_valid_out(wr_valid_out),
    .wr_addr_out(wr_addr_out), .wr_data_out(wr_data_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  logic [7:0]  m_reg [32];
  logic [7:0]  m_hirq;
  logic [7:0]  tx_buf [4];
  logic [7:0]  rx_buf [4];
  logic [12:0] strobes [$];

  always @(negedge clk_in) if (wr_valid_out) strobes.push_back({wr_addr_out, wr_data_out});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mread(input logic [4:0] a);
    if (a == 5'd18) return REV;
    if (a == 5'd25) return m_hirq;
    return m_reg[a];
  endfunction

  task automatic mwrite(input logic [4:0] a, input logic [7:0] d, input bit collide);
    if (a == 5'd25) m_hirq = (m_hirq & ~d) | (collide ? 8'h04 : 8'h00);
    else if (a != 5'd18) m_reg[a] = d;
  endtask

  task automatic mreset();
    for (int i = 0; i < 32; i++) m_reg[i] = 8'h00;
    m_hirq = 8'h00;
  endtask

  task automatic half();
    repeat (8) @(negedge clk_in);
  endtask

  task automatic pulse(input logic [7:0] v);
    @(negedge clk_in) irq_set_in = v;
    @(negedge clk_in) irq_set_in = 8'h00;
    m_hirq = m_hirq | v;
  endtask

  // Shift n bits of tx MSB first (mode 0); rx collects MISO sampled before each rise.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx,
                          input bit collide);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      mosi_in = tx[i];
      half();
      rx = {rx[6:0], miso_out};
      sclk_in = 1'b1;
      for (int k = 0; k < 8; k++) begin
        @(negedge clk_in);
        if (collide) irq_set_in = wr_valid_out ? 8'h04 : 8'h00;
      end
      sclk_in = 1'b0;
    end
  endtask

  task automatic txn(input int n, input bit collide, input string tag);
    logic [7:0] st_exp;
    logic [4:0] a;
    bit         wr;
    int         base;
    logic [7:0] exp_rd [4];
    st_exp = m_hirq;
    a      = tx_buf[0][7:3];
    wr     = tx_buf[0][1];
    base   = strobes.size();
    for (int b = 1; b < n; b++) exp_rd[b] = mread(a);
    ss_in = 1'b0;
    half();
    for (int b = 0; b < n; b++) spi_bits(tx_buf[b], 8, rx_buf[b], collide);
    half();
    ss_in = 1'b1;
    half();
    check({tag, "/status"}, rx_buf[0], st_exp);
    for (int b = 1; b < n; b++) begin
      if (!wr) begin
        check({tag, "/rdata"}, rx_buf[b], exp_rd[b]);
      end else begin
        mwrite(a, tx_buf[b], collide);
        if (base + b - 1 < strobes.size())
          check({tag, "/strobe"}, strobes[base+b-1], {a, tx_buf[b]});
      end
    end
    check({tag, "/nstrobe"}, strobes.size() - base, wr ? n - 1 : 0);
    check({tag, "/int"}, int_out, |(m_hirq & m_reg[26]));
  endtask

  task automatic rd(input logic [4:0] a, input string tag);
    tx_buf[0] = {a, 3'b000};
    tx_buf[1] = 8'h00;
    txn(2, 1'b0, tag);
  endtask

  task automatic wrt(input logic [4:0] a, input logic [7:0] d, input bit collide,
                     input string tag);
    tx_buf[0] = {a, 3'b010};
    tx_buf[1] = d;
    txn(2, collide, tag);
  endtask

  initial begin
    logic [7:0] junk;
    int base;
    mreset();
    repeat (3) @(negedge clk_in);
    check("rst/miso", miso_out, 1'b0);
    check("rst/int", int_out, 1'b0);
    check("rst/wr_valid", wr_valid_out, 1'b0);
    check("rst/wr_addr", wr_addr_out, 5'd0);
    check("rst/wr_data", wr_data_out, 8'd0);
    rst_in = 1'b1;
    half();
    rd(5'd7, "rst_read");

    // write then read
    tx_buf[0] = 8'hD2; tx_buf[1] = 8'h5A; txn(2, 1'b0, "wr26");
    tx_buf[0] = 8'hD0; tx_buf[1] = 8'h00; txn(2, 1'b0, "rd26");

    // revision register
    tx_buf[0] = 8'h90; txn(2, 1'b0, "rev");
    wrt(5'd18, 8'hFF, 1'b0, "rev_wr");
    rd(5'd18, "rev_rd");

    // status and interrupt
    pulse(8'h21);
    wrt(5'd26, 8'h01, 1'b0, "hien");
    check("int_on", int_out, 1'b1);
    tx_buf[0] = 8'hCA; tx_buf[1] = 8'h01; txn(2, 1'b0, "w1c");
    check("int_off", int_out, 1'b0);
    rd(5'd25, "hirq_rd");

    // burst write
    tx_buf[0] = 8'h0A; tx_buf[1] = 8'h11; tx_buf[2] = 8'h22; tx_buf[3] = 8'h33;
    txn(4, 1'b0, "burst");
    rd(5'd1, "burst_rd");

    // abort after 5 data bits
    base = strobes.size();
    ss_in = 1'b0;
    half();
    spi_bits(8'h22, 8, junk, 1'b0);
    spi_bits(8'hEE, 5, junk, 1'b0);
    half();
    ss_in = 1'b1;
    half();
    check("abort/nstrobe", strobes.size() - base, 0);
    rd(5'd4, "abort_rd");

    // set/clear collision on HIRQ bit 2
    wrt(5'd25, 8'h04, 1'b1, "collide");
    rd(5'd25, "collide_rd");

    // reset mid-transfer, then SS held low across release
    wrt(5'd3, 8'hA5, 1'b0, "pre_rst");
    base = strobes.size();
    ss_in = 1'b0;
    half();
    spi_bits(8'h1A, 8, junk, 1'b0);
    rst_in = 1'b0;
    mreset();
    repeat (4) @(negedge clk_in);
    rst_in = 1'b1;
    spi_bits(8'h77, 8, junk, 1'b0);
    half();
    ss_in = 1'b1;
    half();
    check("midrst/nstrobe", strobes.size() - base, 0);
    check("midrst/int", int_out, 1'b0);
    rd(5'd3, "midrst_rd");

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      int n;
      if ($urandom_range(0, 9) < 3) pulse(8'($urandom));
      n = $urandom_range(2, 4);
      tx_buf[0] = {5'($urandom_range(0, 31)), 1'($urandom), 1'($urandom), 1'($urandom)};
      for (int b = 1; b < 4; b++) tx_buf[b] = 8'($urandom);
      txn(n, 1'b0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/max3421e_spi_responder.md
# max3421e_spi_responder

SPI responder (peripheral end) emulating the MAX3421E command/register protocol, so the USB controller's SPI initiator can be exercised in simulation and on a loopback FPGA build without the physical chip. Oversamples the initiator's SCLK/SS/MOSI with the local clock and decodes the command byte. Serves a 32×8 register file, returns the HIRQ status byte during every command phase, and drives an interrupt line. Sits where the MAX3421E would: its ports connect directly to the controller's `ss_out`/`clk_out`/`mosi_out`/`miso_in`/`int_in`.

## Interface
- `REVISION`, 8'h13: constant value returned for register 18; writes to it are ignored.
- `SYNC_STAGES`, 2: flip-flop depth of the input synchronizers (min 2).
- `clk_in` in 1: local oversampling clock.
- `rst_in` in 1: asynchronous, active-low reset.
- `ss_in` in 1: chip select from the initiator, active-low.
- `sclk_in` in 1: SPI clock, mode 0 (CPOL=0, CPHA=0); frequency ≤ `clk_in`/8.
- `mosi_in` in 1: serial data in, MSB first.
- `miso_out` out 1: serial data out, MSB first.
- `int_out` out 1: active-high interrupt; 1 when (HIRQ & HIEN) != 0.
- `irq_set_in` in 8: per-bit one-cycle set pulses into HIRQ (register 25).
- `wr_valid_out` out 1: one-cycle strobe per completed register write.
- `wr_addr_out` out 5: address of the committed write.
- `wr_data_out` out 8: data of the committed write.

## Operation
- Registers: `reg[0..31]`, 8 bits each. Reset value is 0 for all. R18 always reads `REVISION`. R25 = HIRQ, R26 = HIEN.
- Command byte is the first byte after SS falls:
  - bits[7:3] = register address.
  - bit1 = direction: 1 write, 0 read.
  - bit0 = ACKSTAT, accepted and ignored.
  - bit2 is ignored.
- Status phase: while the command byte shifts in, MISO shifts out the HIRQ value captured at the SS falling edge.
- Read transfer: every data byte after the command returns `reg[addr]`. The address does not increment, so repeated bytes re-read the same register. Each byte's value is captured at the start of that byte.
- Write transfer: each completed data byte commits to `reg[addr]` and pulses `wr_valid_out` with `wr_addr_out=addr` and `wr_data_out=byte`. The address does not increment. The strobe pulses even for R18, whose value stays unchanged.
- HIRQ write: write-1-to-clear. The bench-driven `irq_set_in` ORs bits in every cycle. If a set and a clear hit the same bit in the same cycle, the set wins.
- State machine:
  - IDLE: SS high. `miso_out` = 0. On SS fall, load the HIRQ snapshot into the shift register and go to CMD.
  - CMD: shift 8 bits. On the 8th rising edge, latch the command, then go to RDATA or WDATA.
  - RDATA: on the falling edge that ends each byte, load `reg[addr]` into the shift register.
  - WDATA: on every 8th rising edge, commit the byte.
  - From any state, SS rising returns to IDLE. A partial byte is discarded, with no write and no strobe.
- Bit counter: 3 bits, wraps 7→0 at each byte boundary, cleared on SS rising.

## Timing
- Inputs pass through `SYNC_STAGES` flops. Edges are detected on the last stage against a one-flop delayed copy.
- MOSI is sampled on the cycle the synchronized SCLK rising edge is detected.
- MISO changes on the cycle the synchronized SCLK falling edge is detected. The first bit of a byte is valid ≤ `SYNC_STAGES`+1 cycles after the SS fall or after the previous falling edge.
- Write commit and `wr_valid_out` occur 1 cycle after the detected 8th rising edge. The register reads its new value the following cycle.
- `int_out` is registered and follows HIRQ/HIEN with a 1-cycle latency.
- Reset (asynchronous assert, synchronous deassert by the user): all registers are 0, the state is IDLE, and `miso_out`=0, `int_out`=0, `wr_valid_out`=0, `wr_addr_out`=0, `wr_data_out`=0.
- Reset mid-transfer aborts the transfer. After deassertion, a transfer already in progress (SS low) is ignored until SS goes high again.

## Test plan
- **Write then read.** Write cmd 0xD2 (R26, write) with data 0x5A, then read cmd 0xD0. Required: `wr_valid_out` pulses once with addr 26 and data 0x5A; the read data byte = 0x5A.
- **Revision.** Read cmd 0x90 (R18). Required: data byte = 0x13. A write of 0xFF to R18 leaves it reading 0x13.
- **Status and interrupt.** Pulse `irq_set_in`=0x21 and set HIEN=0x01. Required: the next command phase returns 0x21 on MISO and `int_out`=1. Writing 0x01 to R25 → HIRQ=0x20 and `int_out`=0.
- **Burst write.** Cmd 0x0A (R1) followed by 3 bytes 0x11, 0x22, 0x33. Required: three strobes, all with addr 1; R1 ends at 0x33.
- **Abort.** SS rises after 5 data bits of a write. Required: no strobe and the register is unchanged. The next transfer decodes its command correctly.
- **Set/clear collision.** A write of 0x04 to R25 commits in the same cycle as `irq_set_in`=0x04. Required: HIRQ bit 2 remains 1.
